// File: rtl/packer_config_sequencer.sv
// Config-bus sequencer: buffers (id, byte, last) program entries and replays them on configId/configData with tracing paused.
// Latency: commit at edge t -> busy/tracing=0 at t+1, first byte at t+1+DRAIN_CYCLES, one byte per cycle, one GAP per block, one DONE cycle.
// Backpressure: wr_ready only in IDLE with FIFO not full; commit/flush outside IDLE are ignored. Optional macro: PACKER_CFG_REPLAY_EN.
module packer_config_sequencer #(
  parameter int         MAX_CHAINS     = 4,
  parameter int         DEPTH          = 32,
  parameter int         DRAIN_CYCLES   = 4,
  parameter logic [7:0] IDLE_CONFIG_ID = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tracing_req,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_id,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  input  logic       commit,
  input  logic       flush,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       tracing,
  output logic [7:0] configId,
  output logic [7:0] configData
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  if (DEPTH < 2 * MAX_CHAINS || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("DEPTH must be a power of two holding at least one full packer program");
  end
  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("DRAIN_CYCLES must be at least 1");
  end

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] data;
    logic       last;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_STREAM, S_GAP, S_DONE} state_t;

  entry_t         mem_q [DEPTH];
  state_t         state_q, state_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           last_q, last_d;
  logic           wr_ready_q, wr_ready_d, busy_q, busy_d, done_q, done_d;
  logic           error_q, error_d, tracing_q, tracing_d;
  logic [7:0]     cfg_id_q, cfg_id_d, cfg_data_q, cfg_data_d;
  logic           wr_fire, pop, start, do_flush;
  entry_t         head;
  logic [CW-1:0]  cur_rem;

  assign wr_fire = wr_valid & wr_ready_q;

`ifdef PACKER_CFG_REPLAY_EN
  // Replay reads through its own pointer so the stored program survives the sequence.
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] rem_q, rem_d;
  assign head    = mem_q[rp_q];
  assign cur_rem = rem_q;
`else
  assign head    = mem_q[rd_ptr_q];
  assign cur_rem = count_q;
`endif

  // Sequencer next-state, bus outputs and pop decision.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    last_d      = last_q;
    pop         = 1'b0;
    start       = 1'b0;
    do_flush    = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    cfg_id_d    = IDLE_CONFIG_ID;
    cfg_data_d  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          do_flush = 1'b1;
          error_d  = commit;
        end else if (commit) begin
          if (count_q != '0 || wr_fire) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DCW'(DRAIN_CYCLES);
            start       = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q - 1'b1;
        if (drain_cnt_d == '0) begin
          state_d = S_STREAM;
          pop     = 1'b1;
        end
      end
      S_STREAM: begin
        if (last_q) state_d = S_GAP;
        else        pop     = 1'b1;
      end
      S_GAP: begin
        if (cur_rem != '0) begin
          state_d = S_STREAM;
          pop     = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The byte popped here is shown next cycle; the final entry always closes a block.
    if (pop) begin
      cfg_id_d   = head.id;
      cfg_data_d = head.data;
      last_d     = head.last | (cur_rem == CW'(1));
    end
    busy_d    = (state_d != S_IDLE);
    tracing_d = (state_d == S_IDLE) ? tracing_req : 1'b0;
  end

  // FIFO pointer and occupancy bookkeeping; writes and pops never share a cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
`ifdef PACKER_CFG_REPLAY_EN
    rp_d  = rp_q;
    rem_d = rem_q;
    if (start) begin
      rp_d  = rd_ptr_q;
      rem_d = count_q + CW'(wr_fire);
    end else if (pop) begin
      rp_d  = rp_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end
`endif
    if (do_flush) begin
      // A write presented alongside flush is discarded with the rest.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
`ifndef PACKER_CFG_REPLAY_EN
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_d - 1'b1;
      end
`endif
    end
    wr_ready_d = (state_d == S_IDLE) && (count_d < CW'(DEPTH));
  end

  // Program storage; no reset needed since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (wr_fire && !do_flush) mem_q[wr_ptr_q] <= '{id: wr_id, data: wr_data, last: wr_last};
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_q      <= 1'b0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      tracing_q   <= 1'b0;
      cfg_id_q    <= IDLE_CONFIG_ID;
      cfg_data_q  <= 8'h00;
`ifdef PACKER_CFG_REPLAY_EN
      rp_q        <= '0;
      rem_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_q      <= last_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      tracing_q   <= tracing_d;
      cfg_id_q    <= cfg_id_d;
      cfg_data_q  <= cfg_data_d;
`ifdef PACKER_CFG_REPLAY_EN
      rp_q        <= rp_d;
      rem_q       <= rem_d;
`endif
    end
  end

  assign wr_ready   = wr_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign tracing    = tracing_q;
  assign configId   = cfg_id_q;
  assign configData = cfg_data_q;

endmodule

// File: tb/tb_packer_config_sequencer.sv
// Self-checking bench for packer_config_sequencer: directed table, hand sequences and randomized programs.
// Expected bus traces are derived from the program list: drain cycles, bytes, a gap after each block, one done cycle.
// Inputs change 1ns after the rising edge and outputs are sampled there too.
module tb_packer_config_sequencer;
  localparam int         DEPTH   = 32;
  localparam int         DRAIN   = 4;
  localparam logic [7:0] IDLE_ID = 8'hFF;

  logic       clk = 1'b0;
  logic       reset, tracing_req, wr_valid, wr_ready, wr_last, commit, flush;
  logic       busy, done, error, tracing;
  logic [7:0] wr_id, wr_data, configId, configData;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] id;
    logic [7:0] data;
    logic       last;
  } ent_t;
  ent_t model_q[$];

  typedef struct {
    int pre_n; bit wr; bit cm; bit fl; bit trq;
    bit exp_err; bit exp_busy; bit exp_trac;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  packer_config_sequencer #(.MAX_CHAINS(4), .DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN), .IDLE_CONFIG_ID(IDLE_ID)) dut (
    .clk(clk), .reset(reset), .tracing_req(tracing_req),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_id(wr_id), .wr_data(wr_data), .wr_last(wr_last),
    .commit(commit), .flush(flush), .busy(busy), .done(done), .error(error), .tracing(tracing),
    .configId(configId), .configData(configData)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic write_entry(input logic [7:0] id, input logic [7:0] data, input logic last);
    ent_t e;
    logic acc;
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, model_q.size() < DEPTH});
    wr_valid = 1'b1; wr_id = id; wr_data = data; wr_last = last;
    acc = wr_ready;
    step();
    wr_valid = 1'b0;
    if (acc) begin
      e.id = id; e.data = data; e.last = last;
      model_q.push_back(e);
    end
  endtask

  task automatic flush_fifo();
    flush = 1'b1;
    step();
    flush = 1'b0;
    model_q.delete();
  endtask

  // Issues commit, then checks every cycle against the trace built from model_q.
  task automatic run_commit(input string nm, input bit noise, input bit with_wr,
                            output int first_k, output int done_k);
    int   eid[$];
    int   edat[$];
    ent_t e;
    logic [31:0] act, exp, mask;
    if (with_wr) begin
      e.id = 8'($urandom_range(0, 7)); e.data = 8'($urandom); e.last = 1'($urandom_range(0, 1));
      wr_valid = 1'b1; wr_id = e.id; wr_data = e.data; wr_last = e.last;
      model_q.push_back(e);
    end
    for (int i = 0; i < DRAIN; i++) begin eid.push_back(IDLE_ID); edat.push_back(-1); end
    for (int i = 0; i < model_q.size(); i++) begin
      eid.push_back(model_q[i].id); edat.push_back(model_q[i].data);
      if (model_q[i].last || i == model_q.size() - 1) begin eid.push_back(IDLE_ID); edat.push_back(0); end
    end
    commit = 1'b1;
    step();
    commit = 1'b0; wr_valid = 1'b0;
    first_k = -1; done_k = -1;
    for (int k = 0; k <= eid.size(); k++) begin
      if (first_k < 0 && configId !== IDLE_ID) first_k = k + 1;
      if (done_k < 0 && done === 1'b1) done_k = k + 1;
      act = {11'd0, busy, tracing, done, error, wr_ready, configId, configData};
      if (k < eid.size()) begin
        exp  = {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'(eid[k]), (edat[k] < 0) ? 8'h00 : 8'(edat[k])};
        mask = (edat[k] < 0) ? 32'hFFFF_FF00 : 32'hFFFF_FFFF;
      end else begin
        exp  = {11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, IDLE_ID, 8'h00};
        mask = 32'hFFFF_FF00;
      end
      chk($sformatf("%s_cyc%0d", nm, k + 1), act & mask, exp & mask);
      if (noise) begin
        commit = 1'($urandom); flush = 1'($urandom); wr_valid = 1'($urandom);
        wr_id = 8'h5A; wr_data = 8'hA5; wr_last = 1'b1;
      end
      step();
    end
    commit = 1'b0; flush = 1'b0; wr_valid = 1'b0;
`ifndef PACKER_CFG_REPLAY_EN
    model_q.delete();
`endif
    act = {26'd0, busy, tracing, done, error, wr_ready, 1'b0};
    exp = {26'd0, 1'b0, tracing_req, 1'b0, 1'b0, model_q.size() < DEPTH, 1'b0};
    chk($sformatf("%s_idle_return", nm), act, exp);
    chk($sformatf("%s_idle_id", nm), {24'd0, configId}, {24'd0, IDLE_ID});
  endtask

  initial begin
    int f, d, w;
    tbl[0] = '{pre_n: 0, wr: 0, cm: 1, fl: 0, trq: 1, exp_err: 1, exp_busy: 0, exp_trac: 1};
    tbl[1] = '{pre_n: 0, wr: 1, cm: 1, fl: 0, trq: 0, exp_err: 0, exp_busy: 1, exp_trac: 0};
    tbl[2] = '{pre_n: 2, wr: 0, cm: 1, fl: 1, trq: 1, exp_err: 1, exp_busy: 0, exp_trac: 1};
    tbl[3] = '{pre_n: 3, wr: 0, cm: 1, fl: 0, trq: 1, exp_err: 0, exp_busy: 1, exp_trac: 0};
    tbl[4] = '{pre_n: 2, wr: 0, cm: 0, fl: 1, trq: 0, exp_err: 0, exp_busy: 0, exp_trac: 0};
    tbl[5] = '{pre_n: 0, wr: 0, cm: 0, fl: 0, trq: 1, exp_err: 0, exp_busy: 0, exp_trac: 1};

    reset = 1'b1; tracing_req = 1'b1; wr_valid = 1'b0; wr_id = 8'h00; wr_data = 8'h00;
    wr_last = 1'b0; commit = 1'b0; flush = 1'b0;
    step(); step();
    chk("reset_vals", {15'd0, tracing, configId, configData, busy, done, error, wr_ready},
        {15'd0, 1'b0, IDLE_ID, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    step();
    chk("post_reset_ready_tracing", {30'd0, wr_ready, tracing}, 32'd3);

    // Single 8-byte block to id 3.
    for (int i = 1; i <= 8; i++) write_entry(8'd3, 8'(i), i == 8);
    run_commit("plan1", 1'b0, 1'b0, f, d);
    chk("plan1_first_byte", f, 32'd5);
    chk("plan1_done", d, 32'd14);
`ifdef PACKER_CFG_REPLAY_EN
    run_commit("plan1_replay", 1'b0, 1'b0, f, d);
    chk("replay_first_byte", f, 32'd5);
    chk("replay_done", d, 32'd14);
    flush_fifo();
`endif

    // Two back-to-back blocks to the same id.
    for (int i = 1; i <= 16; i++) write_entry(8'd3, 8'(i), (i % 8) == 0);
    run_commit("plan2", 1'b0, 1'b0, f, d);
    chk("plan2_byte_to_done", d - f, 32'd18);
    flush_fifo();

    // IDLE commit/flush/write interaction table.
    for (int r = 0; r < 6; r++) begin
      flush_fifo();
      tracing_req = tbl[r].trq;
      step();
      for (int i = 0; i < tbl[r].pre_n; i++) write_entry(8'(i), 8'(8'h10 + i), 1'b0);
      wr_valid = tbl[r].wr; wr_id = 8'd7; wr_data = 8'h77; wr_last = 1'b1;
      commit = tbl[r].cm; flush = tbl[r].fl;
      step();
      wr_valid = 1'b0; commit = 1'b0; flush = 1'b0;
      chk($sformatf("row%0d_err_busy_trac", r), {29'd0, error, busy, tracing},
          {29'd0, tbl[r].exp_err, tbl[r].exp_busy, tbl[r].exp_trac});
      if (tbl[r].exp_busy) begin
        w = 0;
        while (done !== 1'b1 && w < 200) begin step(); w++; end
        chk($sformatf("row%0d_done_seen", r), {31'd0, done}, 32'd1);
        step();
      end
      model_q.delete();
    end

    // Fill to DEPTH, then one extra write must be dropped.
    flush_fifo();
    for (int i = 0; i < DEPTH; i++) write_entry(8'(i % 8), 8'(i), (i % 8) == 7);
    write_entry(8'd6, 8'hEE, 1'b1);
    chk("full_count", model_q.size(), DEPTH);
    run_commit("full", 1'b1, 1'b0, f, d);
    flush_fifo();

    // Reset in the middle of streaming.
    for (int i = 1; i <= 8; i++) write_entry(8'd3, 8'(i), i == 8);
    commit = 1'b1; step(); commit = 1'b0;
    for (int i = 0; i < DRAIN + 2; i++) step();
    chk("pre_reset_byte3", {16'd0, configId, configData}, {16'd0, 8'd3, 8'd3});
    reset = 1'b1; step();
    chk("midreset_vals", {15'd0, tracing, configId, configData, busy, done, error, wr_ready},
        {15'd0, 1'b0, IDLE_ID, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    reset = 1'b0; step();
    model_q.delete();
    commit = 1'b1; step(); commit = 1'b0;
    chk("post_reset_commit_err_busy", {30'd0, error, busy}, 32'd2);

    // Randomized programs against the list model.
    for (int it = 0; it < 20; it++) begin
      flush_fifo();
      tracing_req = 1'($urandom_range(0, 1));
      step();
      for (int i = 0; i < $urandom_range(1, 12); i++) begin
        if ($urandom_range(0, 1) == 1) step();
        write_entry(8'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3) == 0);
      end
      run_commit($sformatf("rnd%0d", it), 1'b1, 1'($urandom_range(0, 1)), f, d);
      chk($sformatf("rnd%0d_first", it), f, DRAIN + 1);
`ifdef PACKER_CFG_REPLAY_EN
      run_commit($sformatf("rnd%0d_rep", it), 1'b0, 1'b0, f, d);
`else
      commit = 1'b1; step(); commit = 1'b0;
      chk($sformatf("rnd%0d_recommit_err_busy", it), {30'd0, error, busy}, 32'd2);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/packer_config_sequencer.md
# packer_config_sequencer

Sequencer that reprograms the dataPacker (and any other block on the shared `configId`/`configData` bus) while tracing is paused. Host software writes a program of (target id, byte) entries into an internal FIFO, then issues `commit`. The block deasserts `tracing`, waits for the datapath to drain, and streams the bytes one per cycle on the config bus. It inserts the idle-id gaps that targets need to reset their byte counters, then restores `tracing`.

## Interface
- `MAX_CHAINS`, 4: chains per target; a full packer program is 2*MAX_CHAINS bytes (cond bytes, then firmware bytes).
- `DEPTH`, 32: FIFO entries (power of two, ≥ 2*MAX_CHAINS).
- `DRAIN_CYCLES`, 4: cycles with `tracing`=0 before the first config byte (≥1).
- `IDLE_CONFIG_ID`, 8'hFF: id driven when no byte is being delivered; never a valid target id.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `tracing_req` in 1: host's desired tracing state.
- `wr_valid` in 1: program entry valid.
- `wr_ready` out 1: FIFO can accept an entry.
- `wr_id` in 8: target config id of the entry.
- `wr_data` in 8: config byte.
- `wr_last` in 1: entry is the final byte of one target's block.
- `commit` in 1: single-cycle request to stream the program.
- `flush` in 1: empty the FIFO (honoured only in IDLE).
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse at sequence end.
- `error` out 1: one-cycle pulse on a rejected commit.
- `tracing` out 1: tracing enable to the datapath.
- `configId` out 8: config bus id.
- `configData` out 8: config bus byte.

## Operation
- FIFO entry is {id, data, last}, 17 bits. A write occurs when `wr_valid & wr_ready`.
- `wr_ready` = 1 only in IDLE with the FIFO not full. It is 0 during reset and in every other state.
- States:
  - IDLE: `tracing` follows `tracing_req` (registered); `configId`=IDLE_CONFIG_ID.
  - DRAIN: `tracing`=0; down-counter loaded with DRAIN_CYCLES.
  - STREAM: pop one entry per cycle; drive `configId`=id and `configData`=data.
  - GAP: one cycle with `configId`=IDLE_CONFIG_ID and `configData`=0.
  - DONE: `done`=1 for one cycle.
- Transitions:
  - IDLE → DRAIN on `commit` with the FIFO non-empty.
  - `commit` with the FIFO empty: pulse `error`, stay in IDLE.
  - DRAIN → STREAM when the counter reaches 0.
  - STREAM → GAP after an entry with last=1, or after the final entry regardless of last.
  - GAP → STREAM if entries remain, else GAP → DONE.
  - DONE → IDLE.
- `commit` outside IDLE is ignored, with no error. `flush` outside IDLE is ignored. `flush` and `commit` in the same IDLE cycle: the flush wins and `error` pulses.
- A write and `commit` in the same IDLE cycle: the entry is accepted and included in the sequence.
- `tracing` stays 0 from DRAIN through DONE. It returns to `tracing_req` on the cycle after DONE.
- Consecutive blocks to the same id are separated by GAP, so each target restarts at byte 0.
- Reset mid-sequence: the FIFO is emptied and the state returns to IDLE. The partially programmed target is left as is; software must re-send it.

## Timing
- Reset values: `tracing`=0, `configId`=IDLE_CONFIG_ID, `configData`=0, `busy`=0, `done`=0, `error`=0, `wr_ready`=0. From the first cycle after reset: `wr_ready`=1.
- All outputs are registered.
- `commit` sampled at edge t:
  - `busy`=1 and `tracing`=0 from t+1.
  - First config byte at t+1+DRAIN_CYCLES.
- K entries in B blocks: bytes occupy K cycles, plus B GAP cycles (B counts the trailing unterminated block, if any), plus 1 DONE cycle.
- `busy` stays 1 through the DONE cycle and drops with the return to IDLE.
- FIFO full (DEPTH entries): `wr_ready`=0; no overwrite.

## Configuration
- `PACKER_CFG_REPLAY_EN`:
  - Defined: STREAM reads through a replay pointer and leaves the FIFO contents intact. After DONE the pointer rewinds, so each later `commit` re-sends the same program. Only `flush` or `reset` empties the FIFO. New writes append.
  - Undefined: entries are consumed by STREAM, the FIFO is empty after DONE, and a second `commit` pulses `error`.

## Test plan
- Write 8 entries to id 3 (bytes 0x01..0x08, last on the 8th), then `commit` at t → `tracing`=0 at t+1; `configId`=3 with data 0x01..0x08 at t+5..t+12; GAP at t+13; `done` at t+14; `tracing` restored at t+15.
- Two 8-byte blocks to id 3 back-to-back → one IDLE_CONFIG_ID cycle between byte 8 and byte 9, 18 cycles from the first byte to `done`.
- `commit` with the FIFO empty → `error` pulse, `busy` stays 0, `tracing` unchanged.
- Write 32 entries → `wr_ready`=0 after the 32nd; a 33rd `wr_valid` is dropped and the FIFO count stays 32.
- Assert `reset` during STREAM after 3 bytes → the next cycle shows the IDLE reset values, and a `commit` afterwards pulses `error`.
- With `PACKER_CFG_REPLAY_EN`: `commit` twice on the same 8-entry program → identical byte streams both times, and no `error`.
